dev_bridge: RTL

CPU-side bus bridge for the memory-mapped peripherals: the requesting end of the word-addressed device bus (2-bit word address, 32-bit write data, write enable, 32-bit read data, level IRQ) that the timers implement as responders. It turns one processor load/store into a fixed-latency device access with a ready pulse. It also latches device interrupt requests into a maskable pending register and presents them as the hardware-interrupt vector for CP0.

---
 rtl/dev_bridge.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dev_bridge.sv
// CPU-side bridge to the word-addressed device bus: one load/store becomes a
// fixed three-cycle device access, and device IRQs feed a maskable pending register.
module dev_bridge #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWd,
    input  logic        PrWe,
    input  logic        PrRe,
    output logic [31:0] PrRd,
    output logic        PrReady,
    output logic        BusErr,
    output logic [1:0]  DevAddr,
    output logic [31:0] DevWd,
    output logic        Dev0We,
    output logic        Dev1We,
    input  logic [31:0] Dev0Rd,
    input  logic [31:0] Dev1Rd,
    input  logic        Dev0IRQ,
    input  logic        Dev1IRQ,
    output logic [5:0]  HWInt,
    output logic        IntReq
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [31:0] DEV0_BASE = BASE;
    localparam logic [31:0] DEV1_BASE = BASE + 32'h10;
    localparam logic [31:0] PEND_ADDR = BASE + 32'h20;
    localparam logic [31:0] MASK_ADDR = BASE + 32'h24;

    state_t      state;
    state_t      next_state;
    logic [31:2] req_addr;
    logic [31:0] req_wd;
    logic        req_store;
    logic [31:0] rd_reg;
    logic        err_reg;
    logic [1:0]  pending;
    logic [1:0]  mask;

    logic        dev0_hit;
    logic        dev1_hit;
    logic        word3;
    logic        pend_hit;
    logic        mask_hit;
    logic        unmapped;
    logic [31:0] load_data;
    logic [1:0]  pend_clr;
    logic        start;

    logic unused_addr_bits;
    assign unused_addr_bits = ^PrAddr[1:0];

    assign start    = (state == IDLE) && (PrWe || PrRe);
    assign dev0_hit = (req_addr[31:4] == DEV0_BASE[31:4]);
    assign dev1_hit = (req_addr[31:4] == DEV1_BASE[31:4]);
    assign word3    = (req_addr[3:2] == 2'd3);
    assign pend_hit = (req_addr[31:2] == PEND_ADDR[31:2]);
    assign mask_hit = (req_addr[31:2] == MASK_ADDR[31:2]);
    assign unmapped = !(dev0_hit || dev1_hit || pend_hit || mask_hit);

    assign DevAddr = req_addr[3:2];
    assign DevWd   = req_wd;

    always_comb begin
        load_data = 32'h0;
        if (dev0_hit)
            load_data = Dev0Rd;
        else if (dev1_hit)
            load_data = Dev1Rd;
        else if (pend_hit)
            load_data = {30'h0, pending};
        else if (mask_hit)
            load_data = {30'h0, mask};
    end

    // Clearing pending only happens on the ACCESS cycle of a store to the pending word.
    always_comb begin
        pend_clr = 2'b00;
        if (state == ACCESS && req_store && pend_hit)
            pend_clr = req_wd[1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        Dev0We     = 1'b0;
        Dev1We     = 1'b0;
        PrReady    = 1'b0;
        BusErr     = 1'b0;
        PrRd       = 32'h0;
        case (state)
            IDLE: begin
                if (PrWe || PrRe)
                    next_state = ACCESS;
            end
            ACCESS: begin
                next_state = DONE;
                Dev0We     = req_store && dev0_hit && !word3;
                Dev1We     = req_store && dev1_hit && !word3;
            end
            DONE: begin
                next_state = IDLE;
                PrReady    = 1'b1;
                BusErr     = err_reg;
                PrRd       = rd_reg;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            req_addr  <= '0;
            req_wd    <= 32'h0;
            req_store <= 1'b0;
            rd_reg    <= 32'h0;
            err_reg   <= 1'b0;
            mask      <= 2'b11;
        end else begin
            if (start) begin
                req_addr  <= PrAddr[31:2];
                req_wd    <= PrWd;
                req_store <= PrWe;
            end
            if (state == ACCESS) begin
                rd_reg  <= req_store ? 32'h0 : load_data;
                err_reg <= unmapped;
                if (req_store && mask_hit)
                    mask <= req_wd[1:0];
            end
        end
    end

    // Set wins over clear; HWInt/IntReq deliberately lag pending by one cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pending <= 2'b00;
            HWInt   <= 6'h0;
            IntReq  <= 1'b0;
        end else begin
            pending <= (pending & ~pend_clr) | {Dev1IRQ, Dev0IRQ};
            HWInt   <= {4'b0, pending & mask};
            IntReq  <= |(pending & mask);
        end
    end

endmodule
